// File: rtl/t_state_sequencer_if.sv
// t_state_sequencer_if: sequencer control inputs and decoder-drive outputs
interface t_state_sequencer_if;
  logic       rdy;
  logic [3:0] last_t;
  logic       early_end;
  logic       halt;
  logic [3:0] t_sel;
  logic       t_en;
  logic       sync;
  logic       last_cycle;
  logic       in_reset_seq;
  logic       halted;
  modport master (
    output rdy, last_t, early_end, halt,
    input  t_sel, t_en, sync, last_cycle, in_reset_seq, halted
  );
  modport slave (
    input  rdy, last_t, early_end, halt,
    output t_sel, t_en, sync, last_cycle, in_reset_seq, halted
  );
endinterface

// File: rtl/t_state_sequencer.sv
// t_state_sequencer: 6502 T-state select/enable sequencer with start-up, stall and JAM handling
module t_state_sequencer #(
  parameter int RESET_CYCLES = 7
) (
  input logic                 clock,
  input logic                 reset_n,
  t_state_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {RSTSEQ, FETCH, EXEC, HALT} state_e;
  localparam logic [3:0] RST_LAST = 4'(RESET_CYCLES - 1);
  state_e     state_q, state_d;
  logic [3:0] t_sel_q, t_sel_d;
  logic [3:0] last_q, last_d;
  logic [3:0] rst_cnt_q, rst_cnt_d;
  logic       at_end;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RSTSEQ;
      t_sel_q   <= '0;
      last_q    <= '0;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      t_sel_q   <= t_sel_d;
      last_q    <= last_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end
  assign at_end = (t_sel_q == last_q) || (t_sel_q == 4'd15);
  // rdy gates only FETCH/EXEC; the start-up count runs regardless
  always_comb begin
    state_d   = state_q;
    t_sel_d   = t_sel_q;
    last_d    = last_q;
    rst_cnt_d = rst_cnt_q;
    case (state_q)
      RSTSEQ: begin
        rst_cnt_d = rst_cnt_q + 4'd1;
        state_d   = (rst_cnt_q == RST_LAST) ? FETCH : RSTSEQ;
        t_sel_d   = '0;
      end
      FETCH: if (bus.rdy) begin
        state_d = bus.halt ? HALT : EXEC;
        t_sel_d = bus.halt ? t_sel_q : 4'd1;
        last_d  = bus.halt ? last_q : ((bus.last_t == 4'd0) ? 4'd1 : bus.last_t);
      end
      EXEC: if (bus.rdy) begin
        state_d = bus.halt ? HALT : ((bus.early_end || at_end) ? FETCH : EXEC);
        t_sel_d = bus.halt ? t_sel_q : ((bus.early_end || at_end) ? 4'd0 : t_sel_q + 4'd1);
      end
      default: ;
    endcase
  end
  assign bus.t_sel        = t_sel_q;
  assign bus.t_en         = (state_q == FETCH) || (state_q == EXEC);
  assign bus.sync         = state_q == FETCH;
  assign bus.last_cycle   = (state_q == EXEC) && at_end;
  assign bus.in_reset_seq = state_q == RSTSEQ;
  assign bus.halted       = state_q == HALT;
endmodule

// File: tb/tb_t_state_sequencer.sv
// tb_t_state_sequencer: vector-table and hand-sequence checks for t_state_sequencer
module tb_t_state_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  t_state_sequencer_if bus ();
  t_state_sequencer #(.RESET_CYCLES(7)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  typedef struct {
    logic       rdy;
    logic [3:0] last_t;
    logic       early_end;
    logic       halt;
    logic [8:0] exp;
  } vec_t;
  vec_t vq[$];
  function automatic void add(input logic r, input logic [3:0] lt, input logic ee, input logic h,
                              input logic [3:0] t, input logic en, input logic sy, input logic lc,
                              input logic rs, input logic hl);
    vec_t v;
    v.rdy = r; v.last_t = lt; v.early_end = ee; v.halt = h;
    v.exp = {t, en, sy, lc, rs, hl};
    vq.push_back(v);
  endfunction
  function automatic logic [8:0] outs();
    return {bus.t_sel, bus.t_en, bus.sync, bus.last_cycle, bus.in_reset_seq, bus.halted};
  endfunction
  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got t_sel=%0d en/sync/last/rst/halt=%b expected t_sel=%0d en/sync/last/rst/halt=%b",
               name, got[8:5], got[4:0], exp[8:5], exp[4:0]);
    end
  endtask
  task automatic drive(input logic r, input logic [3:0] lt, input logic ee, input logic h);
    bus.rdy = r; bus.last_t = lt; bus.early_end = ee; bus.halt = h;
  endtask
  initial begin
    int n;
    drive(1'b1, 4'd0, 1'b0, 1'b0);
    // start-up: rdy and halt must not influence the count
    add(1,0,0,0, 0,0,0,0,1,0);
    add(0,0,0,0, 0,0,0,0,1,0);
    add(1,0,0,1, 0,0,0,0,1,0);
    add(0,0,0,1, 0,0,0,0,1,0);
    add(1,0,0,0, 0,0,0,0,1,0);
    add(1,0,0,0, 0,0,0,0,1,0);
    add(1,0,0,1, 0,0,0,0,1,0);
    // 4-cycle instruction
    add(1,3,0,0, 0,1,1,0,0,0);
    add(1,0,0,0, 1,1,0,0,0,0);
    add(1,0,0,0, 2,1,0,0,0,0);
    add(1,0,0,0, 3,1,0,1,0,0);
    // 6-cycle instruction with 2-cycle stall at t_sel=2
    add(1,5,0,0, 0,1,1,0,0,0);
    add(1,0,0,0, 1,1,0,0,0,0);
    add(0,0,0,0, 2,1,0,0,0,0);
    add(0,0,0,0, 2,1,0,0,0,0);
    add(1,0,0,0, 2,1,0,0,0,0);
    add(1,0,0,0, 3,1,0,0,0,0);
    add(1,0,0,0, 4,1,0,0,0,0);
    add(1,0,0,0, 5,1,0,1,0,0);
    // early end at t_sel=2
    add(1,6,0,0, 0,1,1,0,0,0);
    add(1,0,0,0, 1,1,0,0,0,0);
    add(1,0,1,0, 2,1,0,0,0,0);
    // last_t=0 clamps to a 2-cycle instruction
    add(1,0,0,0, 0,1,1,0,0,0);
    add(1,0,0,0, 1,1,0,1,0,0);
    // FETCH stall does not latch last_t
    add(0,0,0,0, 0,1,1,0,0,0);
    add(1,7,0,0, 0,1,1,0,0,0);
    add(1,0,0,0, 1,1,0,0,0,0);
    add(0,0,1,1, 2,1,0,0,0,0);
    add(1,0,0,0, 2,1,0,0,0,0);
    add(1,0,0,0, 3,1,0,0,0,0);
    add(1,0,1,1, 4,1,0,0,0,0);
    add(1,0,0,0, 4,0,0,0,0,1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    foreach (vq[i]) begin
      drive(vq[i].rdy, vq[i].last_t, vq[i].early_end, vq[i].halt);
      check($sformatf("vec%0d", i), outs(), vq[i].exp);
      @(posedge clock);
      @(negedge clock);
    end
    // HALT holds for 20 cycles whatever the inputs do
    for (int i = 0; i < 20; i++) begin
      drive(i[0], 4'(i), i[1], i[2]);
      @(posedge clock);
      @(negedge clock);
      check($sformatf("halt_hold%0d", i), outs(), {4'd4, 5'b00001});
    end
    reset_n = 1'b0;
    #1 check("halt_reset_async", outs(), {4'd0, 5'b00010});
    #1 reset_n = 1'b1;
    drive(1'b1, 4'd4, 1'b0, 1'b0);
    n = 0;
    while (n < 50) begin
      @(posedge clock);
      #1 n++;
      if (bus.t_en) break;
    end
    total++;
    if (n != 7) begin
      bad++;
      $display("FAIL startup_edges: got %0d expected 7", n);
    end
    check("post_reset_fetch", outs(), {4'd0, 5'b11000});
    repeat (3) @(posedge clock);
    #1 check("exec_t3", outs(), {4'd3, 5'b10000});
    #2 reset_n = 1'b0;
    #1 check("mid_exec_async_reset", outs(), {4'd0, 5'b00010});
    @(negedge clock);
    reset_n = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
